// File: rtl/count_checker.sv
// Receive-side monitor for a free-running up-counter stream. It locks onto a run of
// correct increments, then counts good and bad samples and captures the last mismatch.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] exp_val,
  output logic [WIDTH-1:0] got_val
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int RUN_W = (LOCK_N   < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam int BAD_W = (UNLOCK_N < 2) ? 1 : $clog2(UNLOCK_N + 1);

  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOCK_N);
  localparam logic [BAD_W-1:0] BAD_LIMIT = BAD_W'(UNLOCK_N);

  logic [1:0]       state;
  logic [WIDTH-1:0] ref_val;
  logic [RUN_W-1:0] run_q;
  logic [BAD_W-1:0] bad_q;

  logic [WIDTH-1:0] exp_next;
  logic [RUN_W-1:0] run_inc;
  logic [BAD_W-1:0] bad_inc;
  logic             match;
  logic             sample_locked;

  // The increment is computed in WIDTH bits so max+1 wraps to 0.
  assign exp_next      = ref_val + 1'b1;
  assign match         = (count == exp_next);
  assign run_inc       = run_q + 1'b1;
  assign bad_inc       = bad_q + 1'b1;
  assign sample_locked = in_valid && (state == LOCKED);
  assign locked        = (state == LOCKED);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      ref_val <= '0;
      run_q   <= '0;
      bad_q   <= '0;
      err     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (in_valid) begin
        // Always resync to the observed value so a single skip costs one error.
        ref_val <= count;
        case (state)
          SEARCH: begin
            state <= ACQUIRE;
            run_q <= '0;
          end
          ACQUIRE: begin
            if (match) begin
              run_q <= run_inc;
              if (run_inc == RUN_LIMIT) begin
                state <= LOCKED;
                bad_q <= '0;
              end
            end else begin
              run_q <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              bad_q <= '0;
              wrap  <= (ref_val == {WIDTH{1'b1}}) && (count == '0);
            end else begin
              err   <= 1'b1;
              bad_q <= bad_inc;
              if (bad_inc == BAD_LIMIT) state <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Statistics and capture; clear wins over a same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
      exp_val <= '0;
      got_val <= '0;
    end else if (clear) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
      exp_val <= '0;
      got_val <= '0;
    end else if (sample_locked) begin
      if (match) begin
        if (ok_cnt != {CNT_W{1'b1}}) ok_cnt <= ok_cnt + 1'b1;
      end else begin
        if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
        exp_val <= exp_next;
        got_val <= count;
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed self-checking bench for count_checker: default instance plus a 2-bit
// counter instance and a LOCK_N=1 instance sharing the same stimulus.
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] count;
  logic       clear;

  logic        locked, err, wrap;
  logic [15:0] ok_cnt, err_cnt;
  logic [3:0]  exp_val, got_val;

  logic        locked2, err2, wrap2;
  logic [1:0]  ok_cnt2, err_cnt2;
  logic [3:0]  exp_val2, got_val2;

  logic        locked3, err3, wrap3;
  logic [15:0] ok_cnt3, err_cnt3;
  logic [3:0]  exp_val3, got_val3;

  int tests_run = 0;
  int tests_failed = 0;

  count_checker #(.WIDTH(4), .LOCK_N(3), .UNLOCK_N(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count(count), .clear(clear),
    .locked(locked), .err(err), .wrap(wrap), .ok_cnt(ok_cnt), .err_cnt(err_cnt),
    .exp_val(exp_val), .got_val(got_val)
  );

  count_checker #(.WIDTH(4), .LOCK_N(3), .UNLOCK_N(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count(count), .clear(clear),
    .locked(locked2), .err(err2), .wrap(wrap2), .ok_cnt(ok_cnt2), .err_cnt(err_cnt2),
    .exp_val(exp_val2), .got_val(got_val2)
  );

  count_checker #(.WIDTH(4), .LOCK_N(1), .UNLOCK_N(2), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count(count), .clear(clear),
    .locked(locked3), .err(err3), .wrap(wrap3), .ok_cnt(ok_cnt3), .err_cnt(err_cnt3),
    .exp_val(exp_val3), .got_val(got_val3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 1 ns after the rising edge.
  task automatic step(input logic v, input logic [3:0] c, input logic clr);
    @(negedge clk);
    in_valid = v;
    count    = c;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] v;
    rst = 1'b1;
    in_valid = 1'b0;
    count = 4'h0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_locked",  32'(locked),  32'h0);
    check("reset_err",     32'(err),     32'h0);
    check("reset_wrap",    32'(wrap),    32'h0);
    check("reset_ok_cnt",  32'(ok_cnt),  32'h0);
    check("reset_err_cnt", 32'(err_cnt), 32'h0);
    check("reset_exp_val", 32'(exp_val), 32'h0);
    check("reset_got_val", 32'(got_val), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: 0..F,0..3 clean stream.
    for (int i = 0; i < 20; i++) begin
      v = 4'(i);
      step(1'b1, v, 1'b0);
      check("t1_locked", 32'(locked), (i >= 3) ? 32'h1 : 32'h0);
      check("t1_wrap",   32'(wrap),   (i == 16) ? 32'h1 : 32'h0);
      check("t1_err",    32'(err),    32'h0);
      check("t1_l1_locked", 32'(locked3), (i >= 1) ? 32'h1 : 32'h0);
      if (i == 5) check("t7_sat_ok_2", 32'(ok_cnt2), 32'h2);
      if (i == 8) check("t7_sat_ok_3", 32'(ok_cnt2), 32'h3);
    end
    check("t1_ok_cnt",  32'(ok_cnt),  32'd16);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);
    check("t7_sat_ok_hold", 32'(ok_cnt2), 32'h3);
    check("t1_l1_ok_cnt", 32'(ok_cnt3), 32'd18);

    // Test 2: single skip while locked (4,5,6 bring the stream up to the 5,6,9,A,B case).
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    check("t2_no_err_before", 32'(err), 32'h0);
    step(1'b1, 4'h9, 1'b0);
    check("t2_err_pulse", 32'(err),     32'h1);
    check("t2_exp_val",   32'(exp_val), 32'h7);
    check("t2_got_val",   32'(got_val), 32'h9);
    check("t2_locked",    32'(locked),  32'h1);
    step(1'b1, 4'hA, 1'b0);
    check("t2_err_drop",  32'(err),     32'h0);
    step(1'b1, 4'hB, 1'b0);
    check("t2_locked_end", 32'(locked),  32'h1);
    check("t2_err_cnt",    32'(err_cnt), 32'd1);
    check("t2_ok_cnt",     32'(ok_cnt),  32'd21);

    // Test 3: count C..4 cleanly, then 5,6,9,2 drops lock, 3,4,5,6 re-locks.
    for (int i = 12; i < 21; i++) begin
      v = 4'(i);
      step(1'b1, v, 1'b0);
      check("t3_pre_err", 32'(err), 32'h0);
    end
    step(1'b1, 4'h5, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    check("t3_ok_cnt", 32'(ok_cnt), 32'd32);
    step(1'b1, 4'h9, 1'b0);
    check("t3_err1",    32'(err),    32'h1);
    check("t3_locked1", 32'(locked), 32'h1);
    step(1'b1, 4'h2, 1'b0);
    check("t3_err2",    32'(err),     32'h1);
    check("t3_unlock",  32'(locked),  32'h0);
    check("t3_err_cnt", 32'(err_cnt), 32'd3);
    check("t3_exp_val", 32'(exp_val), 32'hA);
    check("t3_got_val", 32'(got_val), 32'h2);
    check("t7_sat_err", 32'(err_cnt2), 32'h3);
    step(1'b1, 4'h3, 1'b0);
    check("t3_search_no_err", 32'(err), 32'h0);
    step(1'b1, 4'h4, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    check("t3_not_yet", 32'(locked), 32'h0);
    step(1'b1, 4'h6, 1'b0);
    check("t3_relock",  32'(locked), 32'h1);
    check("t3_ok_hold", 32'(ok_cnt), 32'd32);

    // Test 4: valid toggles every cycle, 7..F,0 with junk on idle cycles.
    for (int i = 7; i < 17; i++) begin
      v = 4'(i);
      step(1'b1, v, 1'b0);
      check("t4_err",  32'(err),  32'h0);
      check("t4_wrap", 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
      step(1'b0, ~v, 1'b0);
      check("t4_idle_err",    32'(err),    32'h0);
      check("t4_idle_wrap",   32'(wrap),   32'h0);
      check("t4_idle_locked", 32'(locked), 32'h1);
    end
    check("t4_ok_cnt",  32'(ok_cnt),  32'd42);
    check("t4_err_cnt", 32'(err_cnt), 32'd3);

    // Test 5: clear coincides with a mismatch sample.
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h5, 1'b1);
    check("t5_err_pulse", 32'(err),     32'h1);
    check("t5_err_cnt",   32'(err_cnt), 32'h0);
    check("t5_ok_cnt",    32'(ok_cnt),  32'h0);
    check("t5_exp_val",   32'(exp_val), 32'h0);
    check("t5_got_val",   32'(got_val), 32'h0);
    check("t5_locked",    32'(locked),  32'h1);
    step(1'b1, 4'h6, 1'b0);
    check("t5_ok_after",  32'(ok_cnt),  32'h1);

    // Test 6: build nonzero state, then asynchronous reset between edges.
    step(1'b1, 4'h9, 1'b0);
    step(1'b1, 4'hA, 1'b0);
    check("t6_pre_err_cnt", 32'(err_cnt), 32'h1);
    check("t6_pre_ok_cnt",  32'(ok_cnt),  32'h2);
    check("t6_pre_locked",  32'(locked),  32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_locked",  32'(locked),  32'h0);
    check("t6_async_ok_cnt",  32'(ok_cnt),  32'h0);
    check("t6_async_err_cnt", 32'(err_cnt), 32'h0);
    check("t6_async_exp_val", 32'(exp_val), 32'h0);
    check("t6_async_got_val", 32'(got_val), 32'h0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = 4'(i);
      step(1'b1, v, 1'b0);
      check("t6_relock", 32'(locked), (i == 3) ? 32'h1 : 32'h0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
